// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//
// Decodes the PS/2 scan-code set 2 byte stream into key events and a held-key
// bitmap for the 13 piano keys.
//
// The decoder tracks the E0 (extended) and F0 (break) prefixes. It drops
// keyboard housekeeping bytes that arrive between sequences. It flags
// typematic repeats. A dangling prefix is abandoned after TIMEOUT_CYCLES
// cycles with no follow-up byte.
//
// Parameters
//   TIMEOUT_CYCLES   max gap between a prefix byte and the byte completing it (>= 2)
//
// Ports
//   CLOCK_50         in   system clock
//   reset            in   synchronous, active-high reset
//   received_data    in   [7:0] byte from the PS/2 controller
//   received_data_en in   single-cycle strobe qualifying received_data
//   key_down         out  [12:0] bit i set while piano key i is held
//   any_key_down     out  OR of key_down, registered alongside it
//   event_valid      out  one-cycle pulse per completed key event
//   event_make       out  1 = press, 0 = release
//   event_extended   out  sequence carried the E0 prefix
//   event_repeat     out  make of a key that was already held
//   event_code       out  [7:0] final (non-prefix) scan code
//   event_key        out  [3:0] piano key index 0..12, 4'hF if unmapped/extended
//
// All event_* fields except event_valid hold their value until the next event.
// Outputs appear the cycle after the strobe cycle.

module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  received_data,
    input  logic        received_data_en,
    output logic [12:0] key_down,
    output logic        any_key_down,
    output logic        event_valid,
    output logic        event_make,
    output logic        event_extended,
    output logic        event_repeat,
    output logic [7:0]  event_code,
    output logic [3:0]  event_key
);

    localparam logic [7:0]  CODE_EXT     = 8'hE0;
    localparam logic [7:0]  CODE_BREAK   = 8'hF0;
    localparam logic [3:0]  KEY_NONE     = 4'hF;
    localparam int          NUM_KEYS     = 13;
    localparam logic [21:0] CNT_TERMINAL = 22'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    // Non-extended scan code to piano key index.
    function automatic logic [3:0] map_key(input logic [7:0] code);
        logic [3:0] key;
        case (code)
            8'h1C:   key = 4'd0;   // A
            8'h1D:   key = 4'd1;   // W
            8'h1B:   key = 4'd2;   // S
            8'h24:   key = 4'd3;   // E
            8'h23:   key = 4'd4;   // D
            8'h2B:   key = 4'd5;   // F
            8'h2C:   key = 4'd6;   // T
            8'h34:   key = 4'd7;   // G
            8'h35:   key = 4'd8;   // Y
            8'h33:   key = 4'd9;   // H
            8'h3C:   key = 4'd10;  // U
            8'h3B:   key = 4'd11;  // J
            8'h42:   key = 4'd12;  // K
            default: key = KEY_NONE;
        endcase
        return key;
    endfunction

    // Keyboard housekeeping bytes: BAT result, ACK, resend, echo, errors and
    // the Pause-key E1 prefix. They are only dropped between sequences; inside
    // a prefix they complete the sequence like any other code.
    function automatic logic is_housekeeping(input logic [7:0] code);
        logic hk;
        case (code)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1: hk = 1'b1;
            default:                                         hk = 1'b0;
        endcase
        return hk;
    endfunction

    state_t      state_q,      state_d;
    logic [21:0] cnt_q,        cnt_d;
    logic [12:0] key_down_q,   key_down_d;
    logic        any_q,        any_d;
    logic        ev_valid_q,   ev_valid_d;
    logic        ev_make_q,    ev_make_d;
    logic        ev_ext_q,     ev_ext_d;
    logic        ev_rep_q,     ev_rep_d;
    logic [7:0]  ev_code_q,    ev_code_d;
    logic [3:0]  ev_key_q,     ev_key_d;

    // Decode of the completing byte.
    logic        emit;
    logic        emit_make;
    logic        emit_ext;
    logic [3:0]  emit_key;
    logic        was_held;

    // Byte-driven FSM plus the prefix timeout.
    always_comb begin
        // NOTE: every signal assigned below gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_make = 1'b0;
        emit_ext  = 1'b0;

        if (received_data_en) begin
            // A byte always wins over the timeout. It is processed in the
            // current prefix state even on the terminal-count cycle.
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (received_data == CODE_EXT) begin
                        state_d = GOT_E0;
                    end else if (received_data == CODE_BREAK) begin
                        state_d = GOT_F0;
                    end else if (!is_housekeeping(received_data)) begin
                        emit      = 1'b1;
                        emit_make = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (received_data == CODE_BREAK) begin
                        state_d = GOT_E0F0;
                    end else if (received_data == CODE_EXT) begin
                        state_d = GOT_E0;
                    end else begin
                        emit      = 1'b1;
                        emit_make = 1'b1;
                        emit_ext  = 1'b1;
                        state_d   = IDLE;
                    end
                end
                GOT_F0: begin
                    if (received_data == CODE_BREAK) begin
                        state_d = GOT_F0;
                    end else if (received_data == CODE_EXT) begin
                        state_d = GOT_E0;  // resync onto a fresh extended sequence
                    end else begin
                        emit    = 1'b1;
                        state_d = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (received_data == CODE_EXT) begin
                        state_d = GOT_E0;
                    end else if (received_data == CODE_BREAK) begin
                        state_d = GOT_E0F0;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_TERMINAL) begin
                state_d = IDLE;  // abandon the dangling prefix silently
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 22'd1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Event fields and held-key bitmap.
    always_comb begin
        key_down_d = key_down_q;
        ev_valid_d = 1'b0;
        ev_make_d  = ev_make_q;
        ev_ext_d   = ev_ext_q;
        ev_rep_d   = ev_rep_q;
        ev_code_d  = ev_code_q;
        ev_key_d   = ev_key_q;
        was_held   = 1'b0;
        emit_key   = emit_ext ? KEY_NONE : map_key(received_data);

        if (emit) begin
            // Look up and update the bitmap with a compare loop. This keeps
            // the 4'hF "no key" index from ever addressing the 13-bit vector.
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (emit_key == 4'(i)) begin
                    was_held      = key_down_q[i];
                    key_down_d[i] = emit_make;
                end
            end
            ev_valid_d = 1'b1;
            ev_make_d  = emit_make;
            ev_ext_d   = emit_ext;
            ev_rep_d   = emit_make & was_held;
            ev_code_d  = received_data;
            ev_key_d   = emit_key;
        end
    end

    assign any_d = |key_down_d;

    always_ff @(posedge CLOCK_50) begin
        // NOTE: state registers use non-blocking assignments so that every
        // flop samples the values from before this edge, whatever the
        // statement order.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_down_q <= '0;
            any_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_make_q  <= 1'b0;
            ev_ext_q   <= 1'b0;
            ev_rep_q   <= 1'b0;
            ev_code_q  <= 8'h00;
            ev_key_q   <= KEY_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_down_q <= key_down_d;
            any_q      <= any_d;
            ev_valid_q <= ev_valid_d;
            ev_make_q  <= ev_make_d;
            ev_ext_q   <= ev_ext_d;
            ev_rep_q   <= ev_rep_d;
            ev_code_q  <= ev_code_d;
            ev_key_q   <= ev_key_d;
        end
    end

    assign key_down       = key_down_q;
    assign any_key_down   = any_q;
    assign event_valid    = ev_valid_q;
    assign event_make     = ev_make_q;
    assign event_extended = ev_ext_q;
    assign event_repeat   = ev_rep_q;
    assign event_code     = ev_code_q;
    assign event_key      = ev_key_q;

endmodule
